mac_route_table: RTL and testbench
==================================

// Module: mac_route_table
// PURPOSE
// Multi-client successor to the switch MAC routing table. It learns the
// source MAC and ingress port of each packet from NETH receive ports, and
// ages entries out on an external tick. It answers destination-port lookups
// from NLKUP independent transmit clients, suppresses hairpin (ingress ==
// egress), treats group MACs as broadcast, and supports a synchronous flush.
// PARAMETERS
// NETH           4          number of Ethernet ports (>=2)
// NLKUP          2          number of lookup client channels (>=1)
// LGTBL          5          log2 of table entries; NTBL = 2**LGTBL
// MACW           48         MAC address width; group bit is MAC[40]
// LGTIMEOUT      8          age counter width, loaded all-ones on learn
// BROADCAST_PORT {NETH{1}}  port mask for broadcast/group destinations
// DEFAULT_PORT   {NETH{1}}  port mask on lookup miss
// PORTS
// i_clk       in   1             clock
// i_reset     in   1             synchronous, active-high reset
// i_flush     in   1             invalidate all entries (one-cycle strobe)
// i_tick      in   1             age strobe: every valid entry's age -1
// RX_VALID    in   NETH          learn request per port
// RX_READY    out  NETH          one-hot grant; transfer = VALID & READY
// RX_SRCMAC   in   NETH*MACW     source MAC per port
// LK_VALID    in   NLKUP         lookup request per client
// LK_READY    out  NLKUP         one-hot grant; transfer = VALID & READY
// LK_DSTMAC   in   NLKUP*MACW    destination MAC per client
// LK_SRCPORT  in   NLKUP*LGETH   ingress port of the packet, LGETH=clog2(NETH)
// LK_RVALID   out  NLKUP         one-cycle result strobe per client
// LK_PORT     out  NLKUP*NETH    egress port mask per client, held until next result
// BEHAVIOUR
// - Reset: all entries invalid, ages 0, RX_READY/LK_READY/LK_RVALID/LK_PORT = 0,
//   and both arbiters point at index 0. Reset mid-lookup drops pending results.
// - RX arbiter: round-robin over RX_VALID. A grant may only be asserted toward
//   an asserted VALID, and the grant moves past a port only after that port
//   transfers. At most one learn per cycle. LK arbiter: identical, independent.
// - Learn (applies on the edge after transfer):
//   - srcmac group bit set: accepted, not stored.
//   - else a valid entry with an equal MAC: refresh age to all-ones and
//     overwrite the port (station moved).
//   - else the lowest-index invalid entry.
//   - else (table full) evict the valid entry with the smallest age; ties go
//     to the lowest index.
//   - Invariant: no two valid entries hold the same MAC.
// - Aging: on i_tick, each valid entry not being written decrements its age.
//   The entry becomes invalid when its age reaches 0. A write in the same
//   cycle as i_tick wins (age = all-ones).
// - Flush: i_flush clears every valid bit next cycle and overrides a
//   same-cycle learn. Lookups in the flush cycle still see the pre-flush table.
// - Lookup: latency 1. A transfer on channel c in cycle N gives LK_RVALID[c]=1
//   in N+1 for exactly one cycle, with LK_PORT[c] registered in N+1. Priority:
//   1. dstmac group bit set (including all-ones) -> BROADCAST_PORT
//   2. else valid entry match -> (1<<entry port)
//   3. else DEFAULT_PORT
//   Then bit LK_SRCPORT is cleared (no hairpin). The result may be 0, meaning
//   drop; clients must accept a 0 mask.
// - Lookup and learn in the same cycle: the lookup sees the table before the
//   write.
// - Out-of-range LK_SRCPORT (>=NETH): no bit is cleared.
// TESTING
// 1. Reset, RX port 2 learns 02:00:00:00:00:05, then client 0 looks up that
//    MAC with srcport 0 -> LK_RVALID[0] one cycle later, LK_PORT = 4'b0100.
// 2. Client 1 looks up an unknown MAC with srcport 1 -> LK_PORT = 4'b1101
//    (default minus ingress). Lookup of ff:ff:ff:ff:ff:ff with srcport 3
//    -> 4'b0111.
// 3. Fill all 32 entries with one tick between learns, then learn a 33rd MAC
//    -> the first-learned entry is evicted; a lookup of it misses and its
//    replacement hits.
// 4. Learn MAC on port 1, relearn the same MAC on port 3, then look up with
//    srcport 3 -> LK_PORT = 0 (hairpin drop), and only one entry is valid.
// 5. Learn a MAC, pulse i_tick 255 times -> entry invalid, lookup yields
//    DEFAULT_PORT. Learn again, assert i_flush -> next-cycle lookup misses.
// 6. All 4 RX and both LK channels held valid for 16 cycles -> each port is
//    granted every 4 cycles and each client every 2 cycles; no grant is ever
//    lost or duplicated.

Source files
------------

// File: rtl/mac_route_table.sv
`default_nettype none
// mac_route_table: learning MAC table with aging and flush, round-robin
// arbitrated learn (per Ethernet port) and lookup (per client) channels.

module mac_route_table_rr #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] sel,
  output logic          act
);
  logic [IW-1:0] ptr;
  int            j;

  // Grant the first requester at or after ptr; ptr only moves on a transfer,
  // and a grant always accompanies a request, so every grant is a transfer.
  always_comb begin
    gnt = '0;
    sel = '0;
    act = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!act && !i_reset && req[j]) begin
        act    = 1'b1;
        gnt[j] = 1'b1;
        sel    = IW'(j);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)  ptr <= '0;
    else if (act) ptr <= (int'(sel) == N - 1) ? '0 : sel + IW'(1);
  end
endmodule

module mac_route_table #(
  parameter  int              NETH           = 4,
  parameter  int              NLKUP          = 2,
  parameter  int              LGTBL          = 5,
  parameter  int              MACW           = 48,
  parameter  int              LGTIMEOUT      = 8,
  parameter  logic [NETH-1:0] BROADCAST_PORT = {NETH{1'b1}},
  parameter  logic [NETH-1:0] DEFAULT_PORT   = {NETH{1'b1}},
  localparam int              LGETH          = $clog2(NETH)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_tick,
  input  logic [NETH-1:0]        RX_VALID,
  output logic [NETH-1:0]        RX_READY,
  input  logic [NETH*MACW-1:0]   RX_SRCMAC,
  input  logic [NLKUP-1:0]       LK_VALID,
  output logic [NLKUP-1:0]       LK_READY,
  input  logic [NLKUP*MACW-1:0]  LK_DSTMAC,
  input  logic [NLKUP*LGETH-1:0] LK_SRCPORT,
  output logic [NLKUP-1:0]       LK_RVALID,
  output logic [NLKUP*NETH-1:0]  LK_PORT
);
  localparam int NTBL = 1 << LGTBL;
  localparam int GBIT = MACW - 8;
  localparam int LKW  = (NLKUP > 1) ? $clog2(NLKUP) : 1;

  logic [NTBL-1:0]      tbl_valid;
  logic [MACW-1:0]      tbl_mac  [NTBL];
  logic [LGETH-1:0]     tbl_port [NTBL];
  logic [LGTIMEOUT-1:0] tbl_age  [NTBL];

  logic [LGETH-1:0]     rx_idx;
  logic                 rx_act;
  logic [LKW-1:0]       lk_idx;
  logic                 lk_act;

  mac_route_table_rr #(.N(NETH)) u_rx_arb (
    .i_clk(i_clk), .i_reset(i_reset), .req(RX_VALID),
    .gnt(RX_READY), .sel(rx_idx), .act(rx_act)
  );

  mac_route_table_rr #(.N(NLKUP)) u_lk_arb (
    .i_clk(i_clk), .i_reset(i_reset), .req(LK_VALID),
    .gnt(LK_READY), .sel(lk_idx), .act(lk_act)
  );

  logic [MACW-1:0]      rx_mac;
  logic                 learn_en;
  logic                 hit_found, free_found;
  logic [LGTBL-1:0]     hit_idx, free_idx, old_idx, wr_idx;
  logic [LGTIMEOUT-1:0] min_age;

  assign rx_mac   = RX_SRCMAC[int'(rx_idx)*MACW +: MACW];
  assign learn_en = rx_act && !rx_mac[GBIT] && !i_flush;

  // Learn target: existing station, else first free slot, else oldest entry.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    min_age    = '1;
    for (int e = 0; e < NTBL; e++) begin
      if (!hit_found && tbl_valid[e] && tbl_mac[e] == rx_mac) begin
        hit_found = 1'b1;
        hit_idx   = LGTBL'(e);
      end
      if (!free_found && !tbl_valid[e]) begin
        free_found = 1'b1;
        free_idx   = LGTBL'(e);
      end
      if (tbl_valid[e] && (e == 0 || tbl_age[e] < min_age)) begin
        min_age = tbl_age[e];
        old_idx = LGTBL'(e);
      end
    end
    wr_idx = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tbl_valid <= '0;
      for (int e = 0; e < NTBL; e++) begin
        tbl_mac[e]  <= '0;
        tbl_port[e] <= '0;
        tbl_age[e]  <= '0;
      end
    end else begin
      for (int e = 0; e < NTBL; e++) begin
        if (i_flush) begin
          tbl_valid[e] <= 1'b0;
        end else if (learn_en && int'(wr_idx) == e) begin
          tbl_valid[e] <= 1'b1;
          tbl_mac[e]   <= rx_mac;
          tbl_port[e]  <= rx_idx;
          tbl_age[e]   <= '1;
        end else if (i_tick && tbl_valid[e]) begin
          tbl_age[e] <= tbl_age[e] - LGTIMEOUT'(1);
          if (tbl_age[e] == LGTIMEOUT'(1)) tbl_valid[e] <= 1'b0;
        end
      end
    end
  end

  logic [MACW-1:0]  lk_mac;
  logic [LGETH-1:0] lk_src;
  logic [NETH-1:0]  lk_res;
  logic             lk_found;

  assign lk_mac = LK_DSTMAC[int'(lk_idx)*MACW +: MACW];
  assign lk_src = LK_SRCPORT[int'(lk_idx)*LGETH +: LGETH];

  always_comb begin
    lk_res   = DEFAULT_PORT;
    lk_found = 1'b0;
    if (lk_mac[GBIT]) begin
      lk_res = BROADCAST_PORT;
    end else begin
      for (int e = 0; e < NTBL; e++) begin
        if (!lk_found && tbl_valid[e] && tbl_mac[e] == lk_mac) begin
          lk_found = 1'b1;
          lk_res   = {{(NETH-1){1'b0}}, 1'b1} << tbl_port[e];
        end
      end
    end
    if (int'(lk_src) < NETH) lk_res[lk_src] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      LK_RVALID <= '0;
      LK_PORT   <= '0;
    end else begin
      LK_RVALID <= '0;
      if (lk_act) begin
        LK_RVALID[lk_idx]                   <= 1'b1;
        LK_PORT[int'(lk_idx)*NETH +: NETH]  <= lk_res;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mac_route_table.sv
`default_nettype none
// Self-checking bench for mac_route_table against a table-level reference model.
module tb_mac_route_table;
  logic         i_clk = 1'b0;
  logic         i_reset, i_flush, i_tick;
  logic [3:0]   RX_VALID, RX_READY;
  logic [191:0] RX_SRCMAC;
  logic [1:0]   LK_VALID, LK_READY, LK_RVALID;
  logic [95:0]  LK_DSTMAC;
  logic [3:0]   LK_SRCPORT;
  logic [7:0]   LK_PORT;

  mac_route_table dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_tick(i_tick),
    .RX_VALID(RX_VALID), .RX_READY(RX_READY), .RX_SRCMAC(RX_SRCMAC),
    .LK_VALID(LK_VALID), .LK_READY(LK_READY), .LK_DSTMAC(LK_DSTMAC),
    .LK_SRCPORT(LK_SRCPORT), .LK_RVALID(LK_RVALID), .LK_PORT(LK_PORT)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the table as plain arrays plus arbiter pointers.
  bit          m_valid [32];
  logic [47:0] m_mac   [32];
  int          m_port  [32];
  int          m_age   [32];
  int          m_rx_ptr, m_lk_ptr;
  logic [3:0]  exp_port [2];

  logic [47:0] rx_mac_a [4];
  logic [47:0] lk_mac_a [2];
  int          lk_src_a [2];

  function automatic logic [47:0] mk(input int grp, input int n);
    return {(grp != 0) ? 8'h03 : 8'h02, 32'h0, 8'(n)};
  endfunction

  function automatic int rr_pick(input logic [3:0] v, input int ptr, input int n);
    for (int k = 0; k < n; k++)
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  function automatic logic [3:0] m_lookup(input logic [47:0] mac, input int src);
    logic [3:0] r = 4'hf;
    if (!mac[40])
      for (int e = 0; e < 32; e++)
        if (m_valid[e] && m_mac[e] == mac) r = 4'b1 << m_port[e];
    r[src] = 1'b0;
    return r;
  endfunction

  task automatic do_reset();
    i_reset = 1'b1; i_flush = 1'b0; i_tick = 1'b0;
    RX_VALID = '1; LK_VALID = '1; RX_SRCMAC = '0; LK_DSTMAC = '0; LK_SRCPORT = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_rx_ready", 64'(RX_READY), 0);
    check("rst_lk_ready", 64'(LK_READY), 0);
    check("rst_rvalid", 64'(LK_RVALID), 0);
    check("rst_lk_port", 64'(LK_PORT), 0);
    i_reset = 1'b0; RX_VALID = '0; LK_VALID = '0;
    for (int e = 0; e < 32; e++) begin m_valid[e] = 0; m_age[e] = 0; end
    m_rx_ptr = 0; m_lk_ptr = 0; exp_port[0] = '0; exp_port[1] = '0;
  endtask

  // One clock: drive requests, check grants, advance model, check results.
  task automatic cycle(input logic [3:0] rxv, input logic [1:0] lkv,
                       input logic tick, input logic flush);
    int gr, gl, tgt;
    logic [3:0] exp_lk;
    RX_VALID = rxv; LK_VALID = lkv; i_tick = tick; i_flush = flush;
    for (int p = 0; p < 4; p++) RX_SRCMAC[p*48 +: 48] = rx_mac_a[p];
    for (int c = 0; c < 2; c++) begin
      LK_DSTMAC[c*48 +: 48] = lk_mac_a[c];
      LK_SRCPORT[c*2 +: 2]  = 2'(lk_src_a[c]);
    end
    #1;
    gr = rr_pick(rxv, m_rx_ptr, 4);
    gl = rr_pick({2'b00, lkv}, m_lk_ptr, 2);
    check("rx_ready", 64'(RX_READY), (gr < 0) ? 64'd0 : 64'd1 << gr);
    check("lk_ready", 64'(LK_READY), (gl < 0) ? 64'd0 : 64'd1 << gl);
    exp_lk = (gl >= 0) ? m_lookup(lk_mac_a[gl], lk_src_a[gl]) : 4'h0;
    tgt = -1;
    if (gr >= 0 && !rx_mac_a[gr][40] && !flush) begin
      for (int e = 0; e < 32; e++)
        if (tgt < 0 && m_valid[e] && m_mac[e] == rx_mac_a[gr]) tgt = e;
      for (int e = 0; e < 32; e++)
        if (tgt < 0 && !m_valid[e]) tgt = e;
      if (tgt < 0) begin
        tgt = 0;
        for (int e = 1; e < 32; e++) if (m_age[e] < m_age[tgt]) tgt = e;
      end
    end
    @(posedge i_clk);
    #1;
    if (gr >= 0) m_rx_ptr = (gr + 1) % 4;
    if (gl >= 0) begin m_lk_ptr = (gl + 1) % 2; exp_port[gl] = exp_lk; end
    for (int e = 0; e < 32; e++) begin
      if (flush) m_valid[e] = 0;
      else if (e == tgt) begin
        m_valid[e] = 1; m_mac[e] = rx_mac_a[gr]; m_port[e] = gr; m_age[e] = 255;
      end else if (tick && m_valid[e]) begin
        m_age[e]--;
        if (m_age[e] == 0) m_valid[e] = 0;
      end
    end
    check("lk_rvalid", 64'(LK_RVALID), (gl < 0) ? 64'd0 : 64'd1 << gl);
    check("lk_port0", 64'(LK_PORT[3:0]), 64'(exp_port[0]));
    check("lk_port1", 64'(LK_PORT[7:4]), 64'(exp_port[1]));
    RX_VALID = '0; LK_VALID = '0; i_tick = 1'b0; i_flush = 1'b0;
  endtask

  task automatic learn(input int p, input logic [47:0] mac);
    rx_mac_a[p] = mac;
    cycle(4'b1 << p, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic lookup(input int c, input logic [47:0] mac, input int src);
    lk_mac_a[c] = mac; lk_src_a[c] = src;
    cycle(4'b0000, 2'b1 << c, 1'b0, 1'b0);
  endtask

  initial begin
    for (int p = 0; p < 4; p++) rx_mac_a[p] = '0;
    for (int c = 0; c < 2; c++) begin lk_mac_a[c] = '0; lk_src_a[c] = 0; end

    do_reset();
    learn(2, 48'h020000000005);
    lookup(0, 48'h020000000005, 0);
    check("t1_hit", 64'(LK_PORT[3:0]), 64'b0100);
    lookup(1, 48'h02000000abcd, 1);
    check("t2_miss", 64'(LK_PORT[7:4]), 64'b1101);
    lookup(1, 48'hffffffffffff, 3);
    check("t2_bcast", 64'(LK_PORT[7:4]), 64'b0111);

    do_reset();
    for (int i = 0; i < 32; i++) begin
      learn(i % 4, mk(0, 100 + i));
      cycle(4'b0000, 2'b00, 1'b1, 1'b0);
    end
    learn(1, mk(0, 200));
    lookup(0, mk(0, 100), 0);
    check("t3_evicted", 64'(LK_PORT[3:0]), 64'b1110);
    lookup(0, mk(0, 200), 0);
    check("t3_new", 64'(LK_PORT[3:0]), 64'b0010);
    lookup(1, mk(0, 101), 0);
    check("t3_kept", 64'(LK_PORT[7:4]), 64'b0010);

    do_reset();
    learn(1, mk(0, 5));
    learn(3, mk(0, 5));
    lookup(0, mk(0, 5), 3);
    check("t4_hairpin", 64'(LK_PORT[3:0]), 64'b0000);

    do_reset();
    learn(2, mk(0, 7));
    repeat (254) cycle(4'b0000, 2'b00, 1'b1, 1'b0);
    lookup(0, mk(0, 7), 0);
    check("t5_age1", 64'(LK_PORT[3:0]), 64'b0100);
    cycle(4'b0000, 2'b00, 1'b1, 1'b0);
    lookup(0, mk(0, 7), 0);
    check("t5_aged", 64'(LK_PORT[3:0]), 64'b1110);
    learn(3, mk(0, 8));
    lk_mac_a[0] = mk(0, 8); lk_src_a[0] = 0;
    cycle(4'b0000, 2'b01, 1'b0, 1'b1);
    check("t5_preflush", 64'(LK_PORT[3:0]), 64'b1000);
    lookup(0, mk(0, 8), 0);
    check("t5_flushed", 64'(LK_PORT[3:0]), 64'b1110);
    rx_mac_a[1] = mk(0, 9);
    cycle(4'b0010, 2'b00, 1'b0, 1'b1);
    lookup(1, mk(0, 9), 0);
    check("t5_flush_learn", 64'(LK_PORT[7:4]), 64'b1110);

    do_reset();
    for (int p = 0; p < 4; p++) rx_mac_a[p] = mk(0, 40 + p);
    lk_mac_a[0] = mk(0, 41); lk_src_a[0] = 0;
    lk_mac_a[1] = mk(1, 3);  lk_src_a[1] = 2;
    repeat (16) cycle(4'b1111, 2'b11, 1'b0, 1'b0);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 4; p++) rx_mac_a[p] = mk(($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 39));
      for (int c = 0; c < 2; c++) begin
        lk_mac_a[c] = mk(($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 39));
        lk_src_a[c] = $urandom_range(0, 3);
      end
      cycle(4'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
